sprite_plotter: RTL and testbench
=================================

Name: sprite_plotter

Overview:
- Downstream consumer of the ghost/player control blocks: takes a sprite position, 5x5 shape bitmap and colour, and emits a serial pixel stream to the VGA adapter plot interface (x, y, colour, plot).
- Per draw request: first erases the sprite at its previously drawn position/shape with the background colour, then draws it at the new position.
- Handles screen-edge clipping.
- One instance sits between each sprite controller and the shared VGA write arbiter.

Parameters:
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed
- DIM, 5, sprite edge length (bitmap is DIM*DIM bits); design and tests cover 5 only

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  single-cycle draw request; sampled only in IDLE
- x_in  in  8  new sprite top-left x
- y_in  in  7  new sprite top-left y
- shape  in  25  bitmap; bit 24 = row0/col0, index i = row*5+col maps to shape[24-i]
- colour  in  3  sprite colour
- bg_colour  in  3  erase colour
- x_plot  out  8  pixel x (registered)
- y_plot  out  7  pixel y (registered)
- colour_out  out  3  pixel colour (registered)
- plot  out  1  pixel write strobe; x_plot/y_plot/colour_out valid when high
- busy  out  1  high from cycle after accepted go until done cycle inclusive
- done  out  1  one-cycle pulse at end of request

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE; all outputs 0; prev_valid=0; prev_x/prev_y/prev_shape=0.
  - An aborted request leaves its pixels on screen; the next request performs no erase.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - On go=1, latch x_in, y_in, shape, colour into cur_* registers; clear idx.
  - Go to ERASE if prev_valid=1, otherwise DRAW.
  - go while not IDLE is ignored; it is neither queued nor latched.
- ERASE:
  - idx steps 0..24, one per cycle; exactly 25 cycles.
  - Each cycle: row=idx/5, col=idx%5.
  - Compute px=prev_x+col and py=prev_y+row in 9/8-bit (no wrap).
  - plot=1 next cycle iff prev_shape[24-idx]=1 && px<SCREEN_W && py<SCREEN_H.
  - When plotting, x_plot=px[7:0], y_plot=py[6:0], colour_out=bg_colour.
  - After idx=24: idx<=0, go to DRAW.
- DRAW:
  - Same iteration over cur_x/cur_y/cur_shape with colour_out=cur colour; 25 cycles; then DONE.
- DONE:
  - done=1 for one cycle.
  - prev_x<=cur_x, prev_y<=cur_y, prev_shape<=cur_shape, prev_valid<=1.
  - Return to IDLE. A go in the cycle after done is accepted.
- Outputs are registered, one cycle behind the idx that produced them.
  - When plot=0, x_plot/y_plot/colour_out hold their last value.
- Latency, with go accepted at cycle 0:
  - First possible plot at cycle 1.
  - Without erase: done at cycle 26.
  - With erase: done at cycle 51.
  - busy covers cycles 1..done.
- Inputs x_in/y_in/shape/colour may change freely after the go cycle; only the latched copies are used.
- bg_colour is read live during ERASE.
- Clipped pixels consume their cycle (plot=0); timing is independent of position and shape content.

Test Plan:
- Reset, then go with x=10, y=20, shape=25'b1111110101101011111110101, colour=3'b100 -> no erase; 19 plot pulses. First is (10,20) colour 4 at cycle 1; last is (14,24) at cycle 25; done at 26.
- Then go with x=11, y=20 -> 19 erase plots with bg_colour=0 at cycles 1..25 (first (10,20)), then 19 draw plots at cycles 26..50 (first (11,20)); done at 51.
- Go with x=158, y=118, same shape (prev cleared by reset) -> only 3 plots: (158,118), (159,118), (158,119). done still at 26.
- Go with x=255, y=0 -> 0 plots, done at 26; the following request erases nothing visible (0 erase plots) and completes at 51.
- Pulse go at cycles 5 and 20 of an active request -> ignored; plot count and done timing unchanged; exactly one done.
- Assert reset at cycle 10 of a DRAW -> next cycle plot=0, busy=0, done=0. A subsequent go at x=10, y=20 skips erase (done at 26).

Source files
------------

// File: rtl/sprite_plotter.sv
// Serialises a DIM x DIM sprite into single-pixel plot strobes: erases the
// previously drawn image with the background colour, then draws the new one.
module sprite_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DIM      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [7:0]         x_in,
  input  logic [6:0]         y_in,
  input  logic [DIM*DIM-1:0] shape,
  input  logic [2:0]         colour,
  input  logic [2:0]         bg_colour,
  output logic [7:0]         x_plot,
  output logic [6:0]         y_plot,
  output logic [2:0]         colour_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int NPIX = DIM * DIM;
  localparam int IW   = $clog2(NPIX);
  localparam int RW   = $clog2(DIM);
  localparam logic [IW-1:0] LAST  = IW'(NPIX - 1);
  localparam logic [RW-1:0] CLAST = RW'(DIM - 1);
  localparam logic [8:0]    XLIM  = 9'(SCREEN_W);
  localparam logic [7:0]    YLIM  = 8'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     row_q, row_d, col_q, col_d;
  logic [7:0]        cur_x_q, cur_x_d, prev_x_q, prev_x_d;
  logic [6:0]        cur_y_q, cur_y_d, prev_y_q, prev_y_d;
  logic [NPIX-1:0]   cur_shape_q, cur_shape_d, prev_shape_q, prev_shape_d;
  logic [2:0]        cur_col_q, cur_col_d;
  logic              prev_valid_q, prev_valid_d;
  logic [7:0]        x_plot_q, x_plot_d;
  logic [6:0]        y_plot_q, y_plot_d;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Pixel datapath: ERASE walks the remembered image, DRAW the latched one.
  logic              erase;
  logic [7:0]        base_x;
  logic [6:0]        base_y;
  logic [NPIX-1:0]   base_shape;
  logic [2:0]        pix_col;
  logic [8:0]        px;
  logic [7:0]        py;
  logic              hit;

  always_comb begin
    erase      = (state_q == S_ERASE);
    base_x     = erase ? prev_x_q     : cur_x_q;
    base_y     = erase ? prev_y_q     : cur_y_q;
    base_shape = erase ? prev_shape_q : cur_shape_q;
    pix_col    = erase ? bg_colour    : cur_col_q;
    px         = {1'b0, base_x} + {{(9-RW){1'b0}}, col_q};
    py         = {1'b0, base_y} + {{(8-RW){1'b0}}, row_q};
    hit        = base_shape[LAST - idx_q] && (px < XLIM) && (py < YLIM);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_shape_d  = cur_shape_q;
    cur_col_d    = cur_col_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_shape_d = prev_shape_q;
    prev_valid_d = prev_valid_q;
    x_plot_d     = x_plot_q;
    y_plot_d     = y_plot_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_x_d     = x_in;
          cur_y_d     = y_in;
          cur_shape_d = shape;
          cur_col_d   = colour;
          idx_d       = '0;
          row_d       = '0;
          col_d       = '0;
          state_d     = prev_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW: begin
        plot_d = hit;
        if (hit) begin
          x_plot_d = px[7:0];
          y_plot_d = py[6:0];
          colour_d = pix_col;
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = erase ? S_DRAW : S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == CLAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d       = 1'b1;
        prev_x_d     = cur_x_q;
        prev_y_d     = cur_y_q;
        prev_shape_d = cur_shape_q;
        prev_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_shape_q  <= '0;
      cur_col_q    <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_shape_q <= '0;
      prev_valid_q <= 1'b0;
      x_plot_q     <= '0;
      y_plot_q     <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_shape_q  <= cur_shape_d;
      cur_col_q    <= cur_col_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_shape_q <= prev_shape_d;
      prev_valid_q <= prev_valid_d;
      x_plot_q     <= x_plot_d;
      y_plot_q     <= y_plot_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign x_plot     = x_plot_q;
  assign y_plot     = y_plot_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: a reference model queues every expected
// plot (cycle, x, y, colour) and the DUT's strobes are popped against it.
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        reset, go;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [24:0] shape;
  logic [2:0]  colour, bg_colour;
  logic [7:0]  x_plot;
  logic [6:0]  y_plot;
  logic [2:0]  colour_out;
  logic        plot, busy, done;

  sprite_plotter dut (
    .clk(clk), .reset(reset), .go(go), .x_in(x_in), .y_in(y_in),
    .shape(shape), .colour(colour), .bg_colour(bg_colour),
    .x_plot(x_plot), .y_plot(y_plot), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  ev_t         sb[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  bit          m_pv;
  int          m_px, m_py;
  logic [24:0] m_ps;

  localparam logic [24:0] S1 = 25'b1111110101101011111110101;
  localparam logic [24:0] S2 = 25'b1000101010001000101010001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference image walk: row-major, one cycle per bitmap cell, clipped cells
  // still consume their cycle.
  task automatic push_img(input int bx, input int by, input logic [24:0] s,
                          input logic [2:0] c, input int off);
    for (int r = 0; r < 5; r++)
      for (int cc = 0; cc < 5; cc++)
        if (s[24 - (r*5 + cc)] && (bx + cc) < 160 && (by + r) < 120)
          sb.push_back('{off + r*5 + cc + 1, 8'(bx + cc), 7'(by + r), c});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_plot",   32'(plot),       32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_x",      32'(x_plot),     32'd0);
    chk("rst_y",      32'(y_plot),     32'd0);
    chk("rst_colour", 32'(colour_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_pv  = 1'b0;
  endtask

  // One draw request. ga/gb: cycles at which a stray go is raised;
  // rst_at: cycle after which reset is asserted (0 = none).
  task automatic request(input int x, input int y, input logic [24:0] s,
                         input logic [2:0] c, input logic [2:0] bg,
                         input int ga, input int gb, input int rst_at);
    int  doff, done_cyc, nplot, nexp;
    ev_t e;
    sb.delete();
    doff = m_pv ? 25 : 0;
    if (m_pv) push_img(m_px, m_py, m_ps, bg, 0);
    push_img(x, y, s, c, doff);
    nexp     = sb.size();
    done_cyc = doff + 26;
    nplot    = 0;
    @(negedge clk);
    go = 1'b1; x_in = 8'(x); y_in = 7'(y); shape = s; colour = c; bg_colour = bg;
    @(posedge clk); #1;
    go = 1'b0; x_in = ~x_in; y_in = ~y_in; shape = ~s; colour = ~c;
    for (int k = 1; k <= done_cyc + 2; k++) begin
      @(posedge clk); #1;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("abort_plot", 32'(plot), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        go    = 1'b0;
        m_pv  = 1'b0;
        return;
      end
      chk("busy", 32'(busy), 32'(k <= done_cyc));
      chk("done", 32'(done), 32'(k == done_cyc));
      if (plot) begin
        nplot++;
        if (sb.size() == 0) chk("extra_plot", 32'(nplot), 32'(nexp));
        else begin
          e = sb.pop_front();
          chk("plot_cycle", 32'(k),          32'(e.cyc));
          chk("plot_x",     32'(x_plot),     32'(e.x));
          chk("plot_y",     32'(y_plot),     32'(e.y));
          chk("plot_col",   32'(colour_out), 32'(e.c));
        end
      end
      go = (k == ga || k == gb);
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
    end
    chk("plot_count", 32'(nplot), 32'(nexp));
    m_pv = 1'b1; m_px = x; m_py = y; m_ps = s;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; x_in = '0; y_in = '0; shape = '0;
    colour = '0; bg_colour = '0;
    repeat (2) @(posedge clk);
    do_reset();

    request(10, 20, S1, 3'b100, 3'b000, 0, 0, 0);    // fresh draw, 19 plots
    request(11, 20, S1, 3'b100, 3'b000, 0, 0, 0);    // erase + redraw
    do_reset();
    request(158, 118, S1, 3'b101, 3'b000, 0, 0, 0);  // corner clipping, 3 plots
    do_reset();
    request(255, 0, S1, 3'b110, 3'b000, 0, 0, 0);    // fully off-screen
    request(20, 30, S1, 3'b001, 3'b000, 0, 0, 0);    // invisible erase
    request(40, 50, S2, 3'b010, 3'b011, 5, 20, 0);   // stray go ignored
    do_reset();
    request(10, 20, S1, 3'b100, 3'b000, 0, 0, 10);   // abort mid-draw
    request(10, 20, S1, 3'b100, 3'b000, 0, 0, 0);    // no erase after abort

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
